// File: rtl/dmux_pkg.sv
// Shared constants and channel index type for the 1:4 distributor.
package dmux_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic [1:0] {
        CH0 = 2'd0,
        CH1 = 2'd1,
        CH2 = 2'd2,
        CH3 = 2'd3
    } chIdx_e;

endpackage

// File: rtl/dmux_slot.sv
// One-entry output buffer for a single distributor channel.
// Optional per-slot drain counter when DMUX_COUNT_EN is defined.
module dmux_slot
    import dmux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iLoad,
    input  logic             iReady,
    input  logic [WIDTH-1:0] iD,
    output logic             oFull,
    output logic [WIDTH-1:0] oData
`ifdef DMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0] oCnt
`endif
);

    logic drain;

    assign drain = oFull & iReady;

    // A load wins over a drain so a same-cycle refill keeps the slot full.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oFull <= 1'b0;
            oData <= '0;
        end else if (iLoad) begin
            oFull <= 1'b1;
            oData <= iD;
        end else if (drain) begin
            oFull <= 1'b0;
        end
    end

`ifdef DMUX_COUNT_EN
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oCnt <= '0;
        end else if (drain) begin
            oCnt <= oCnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/dmux_distributor.sv
// 1:4 demultiplexer with a one-entry valid/ready buffer per channel.
// Define DMUX_COUNT_EN to add 8-bit per-channel drain counters (oCnt0..oCnt3).
module dmux_distributor
    import dmux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic [WIDTH-1:0]  iD,
    input  logic              iS1,
    input  logic              iS0,
    input  logic              iValid,
    output logic              oReady,
    output logic [WIDTH-1:0]  oZ0,
    output logic [WIDTH-1:0]  oZ1,
    output logic [WIDTH-1:0]  oZ2,
    output logic [WIDTH-1:0]  oZ3,
    output logic [NUM_CH-1:0] oValid,
    input  logic [NUM_CH-1:0] iReady
`ifdef DMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0]  oCnt0,
    output logic [CNT_W-1:0]  oCnt1,
    output logic [CNT_W-1:0]  oCnt2,
    output logic [CNT_W-1:0]  oCnt3
`endif
);

    chIdx_e              tgt;
    logic                accept;
    logic [NUM_CH-1:0]   load;
    logic [NUM_CH-1:0]   full;
    logic [WIDTH-1:0]    zArr [NUM_CH];
`ifdef DMUX_COUNT_EN
    logic [CNT_W-1:0]    cntArr [NUM_CH];
`endif

    // Target follows the select lines every cycle; a stalled word only retargets oReady.
    assign tgt    = chIdx_e'({iS1, iS0});
    assign oReady = ~full[tgt] | iReady[tgt];
    assign accept = iValid & oReady;

    for (genvar n = 0; n < NUM_CH; n++) begin : gSlot
        assign load[n] = accept & (tgt == chIdx_e'(2'(n)));

        dmux_slot #(
            .WIDTH (WIDTH)
        ) uSlot (
            .iClk   (iClk),
            .iRst_n (iRst_n),
            .iLoad  (load[n]),
            .iReady (iReady[n]),
            .iD     (iD),
            .oFull  (full[n]),
            .oData  (zArr[n])
`ifdef DMUX_COUNT_EN
            ,
            .oCnt   (cntArr[n])
`endif
        );
    end

    assign oValid = full;
    assign oZ0    = zArr[0];
    assign oZ1    = zArr[1];
    assign oZ2    = zArr[2];
    assign oZ3    = zArr[3];

`ifdef DMUX_COUNT_EN
    assign oCnt0 = cntArr[0];
    assign oCnt1 = cntArr[1];
    assign oCnt2 = cntArr[2];
    assign oCnt3 = cntArr[3];
`endif

endmodule

// File: tb/tb_dmux_distributor.sv
// Scoreboard bench for dmux_distributor: accepted words queue per channel, a monitor pops on drain.
module tb_dmux_distributor;

    localparam int unsigned W = 4;

    logic          iClk;
    logic          iRst_n;
    logic [W-1:0]  iD;
    logic          iS1;
    logic          iS0;
    logic          iValid;
    logic          oReady;
    logic [W-1:0]  oZ0;
    logic [W-1:0]  oZ1;
    logic [W-1:0]  oZ2;
    logic [W-1:0]  oZ3;
    logic [3:0]    oValid;
    logic [3:0]    iReady;
`ifdef DMUX_COUNT_EN
    logic [7:0]    oCnt0;
    logic [7:0]    oCnt1;
    logic [7:0]    oCnt2;
    logic [7:0]    oCnt3;
`endif

    int errors = 0;
    int checks = 0;

    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];
    logic [W-1:0] q2 [$];
    logic [W-1:0] q3 [$];

    dmux_distributor #(.WIDTH(W)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iD     (iD),
        .iS1    (iS1),
        .iS0    (iS0),
        .iValid (iValid),
        .oReady (oReady),
        .oZ0    (oZ0),
        .oZ1    (oZ1),
        .oZ2    (oZ2),
        .oZ3    (oZ3),
        .oValid (oValid),
        .iReady (iReady)
`ifdef DMUX_COUNT_EN
        ,
        .oCnt0  (oCnt0),
        .oCnt1  (oCnt1),
        .oCnt2  (oCnt2),
        .oCnt3  (oCnt3)
`endif
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] zOf(input int ch);
        case (ch)
            0:       return oZ0;
            1:       return oZ1;
            2:       return oZ2;
            default: return oZ3;
        endcase
    endfunction

    task automatic pushExp(input int ch, input logic [W-1:0] d);
        case (ch)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            2:       q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    task automatic flushExp();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
    endtask

    // Monitor: every drain handshake must present the oldest accepted word for that channel.
    always @(negedge iClk) begin
        if (iRst_n) begin
            for (int n = 0; n < 4; n++) begin
                if (oValid[n] && iReady[n]) begin
                    int sz;
                    logic [W-1:0] e;
                    case (n)
                        0:       sz = q0.size();
                        1:       sz = q1.size();
                        2:       sz = q2.size();
                        default: sz = q3.size();
                    endcase
                    if (sz == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL drain_ch%0d: got unexpected word %0h expected none at %0t",
                                 n, zOf(n), $time);
                    end else begin
                        case (n)
                            0:       e = q0.pop_front();
                            1:       e = q1.pop_front();
                            2:       e = q2.pop_front();
                            default: e = q3.pop_front();
                        endcase
                        chk($sformatf("drain_ch%0d", n), 32'(zOf(n)), 32'(e));
                    end
                end
            end
        end
    end

    // One cycle of stimulus; oReady checked mid-cycle and the word queued if it should be taken.
    task automatic step(input logic v, input logic [W-1:0] d, input int ch,
                        input logic [3:0] rdy, input logic expRdy);
        iValid = v;
        iD     = d;
        {iS1, iS0} = 2'(ch);
        iReady = rdy;
        @(negedge iClk);
        if (v) begin
            chk("oReady", 32'(oReady), 32'(expRdy));
            if (expRdy) pushExp(ch, d);
        end
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        iReady = 4'b0000;
    endtask

    task automatic chkZ(input logic [W-1:0] z0, input logic [W-1:0] z1,
                        input logic [W-1:0] z2, input logic [W-1:0] z3);
        chk("oZ0", 32'(oZ0), 32'(z0));
        chk("oZ1", 32'(oZ1), 32'(z1));
        chk("oZ2", 32'(oZ2), 32'(z2));
        chk("oZ3", 32'(oZ3), 32'(z3));
    endtask

    task automatic pulseReset();
        iRst_n = 1'b0;
        flushExp();
        #1;
        chk("rst_oValid", 32'(oValid), 32'h0);
        chkZ(4'h0, 4'h0, 4'h0, 4'h0);
        chk("rst_oReady", 32'(oReady), 32'h1);
        @(negedge iClk);
        iRst_n = 1'b1;
        @(posedge iClk);
        #1;
        chk("post_rst_oReady", 32'(oReady), 32'h1);
    endtask

    initial begin
        iRst_n = 1'b0;
        iValid = 1'b0;
        iD     = '0;
        iS1    = 1'b0;
        iS0    = 1'b0;
        iReady = 4'b0000;
        @(posedge iClk);
        #1;
        pulseReset();

        // Single accept into channel 1, one-cycle latency
        step(1'b1, 4'b0011, 1, 4'b0000, 1'b1);
        chk("ch1_oValid", 32'(oValid), 32'h2);
        chkZ(4'h0, 4'h3, 4'h0, 4'h0);

        // Stalled full channel 2 refuses a new word and holds its data
        step(1'b1, 4'b1100, 2, 4'b0000, 1'b1);
        chk("ch2_oValid", 32'(oValid), 32'h6);
        step(1'b1, 4'b1111, 2, 4'b0000, 1'b0);
        chk("stall_oZ2", 32'(oZ2), 32'hC);
        step(1'b1, 4'b1111, 2, 4'b0010, 1'b0);
        chk("stall_oZ2b", 32'(oZ2), 32'hC);
        chk("stall_oValid", 32'(oValid), 32'h4);
        step(1'b0, 4'b1111, 2, 4'b0100, 1'b0);
        chk("ch2_drained", 32'(oValid), 32'h0);
        chk("ch2_retained", 32'(oZ2), 32'hC);

        // Same-cycle drain and refill of channel 3, no bubble
        step(1'b1, 4'b1010, 3, 4'b0000, 1'b1);
        step(1'b1, 4'b0010, 1, 4'b0000, 1'b1);
        chk("pre_bypass", 32'(oValid), 32'hA);
        step(1'b1, 4'b0101, 3, 4'b1000, 1'b1);
        chk("bypass_oValid", 32'(oValid), 32'hA);
        chk("bypass_oZ3", 32'(oZ3), 32'h5);

        // Reset mid-stream with oValid=1010
        pulseReset();
        step(1'b1, 4'b0110, 3, 4'b0000, 1'b1);
        chk("fresh_oValid", 32'(oValid), 32'h8);
        chkZ(4'h0, 4'h0, 4'h0, 4'h6);
        step(1'b0, 4'b0000, 0, 4'b1000, 1'b0);

        // Fill all four channels, then drain all at once
        step(1'b1, 4'b0000, 0, 4'b0000, 1'b1);
        step(1'b1, 4'b0011, 1, 4'b0000, 1'b1);
        step(1'b1, 4'b1100, 2, 4'b0000, 1'b1);
        step(1'b1, 4'b1111, 3, 4'b0000, 1'b1);
        chk("all_full", 32'(oValid), 32'hF);
        step(1'b0, 4'b0000, 0, 4'b1111, 1'b0);
        chk("all_drained", 32'(oValid), 32'h0);
        chkZ(4'h0, 4'h3, 4'hC, 4'hF);

        // Words presented without iValid are ignored
        step(1'b0, 4'b1001, 1, 4'b0000, 1'b0);
        chk("novalid_oValid", 32'(oValid), 32'h0);
        chk("novalid_oZ1", 32'(oZ1), 32'h3);

`ifdef DMUX_COUNT_EN
        // 257 drains of channel 0 from a cleared counter wrap to 8'h01
        pulseReset();
        chk("cnt0_reset", 32'(oCnt0), 32'h0);
        for (int i = 0; i < 257; i++) begin
            step(1'b1, 4'(i), 0, 4'b0001, 1'b1);
        end
        step(1'b0, 4'b0000, 0, 4'b0001, 1'b0);
        chk("cnt0_wrap", 32'(oCnt0), 32'h01);
        chk("cnt1_idle", 32'(oCnt1), 32'h00);
`endif

        repeat (2) @(posedge iClk);
        chk("q_left", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmux_distributor.md
DMUX_DISTRIBUTOR -- requirements
Module: dmux_distributor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width of input and each output channel.
REQ-002 SHALL have port iClk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port iRst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port iD  input  WIDTH  data word to distribute.
REQ-005 SHALL have port iS1  input  1  select MSB.
REQ-006 SHALL have port iS0  input  1  select LSB.
REQ-007 SHALL have port iValid  input  1  iD/iS1/iS0 valid this cycle.
REQ-008 SHALL have port oReady  output  1  block accepts the presented word this cycle.
REQ-009 SHALL have ports oZ0..oZ3  output  WIDTH each  channel data, channel n = {iS1,iS0}.
REQ-010 SHALL have port oValid  output  4  per-channel data-valid, bit n for oZn.
REQ-011 SHALL have port iReady  input  4  per-channel consumer ready, bit n for oZn.

Function
REQ-012 SHALL hold one-entry buffer per channel (data register + full flag driving oValid[n]).
REQ-013 SHALL compute target channel t = {iS1,iS0} combinationally each cycle; no select latching before accept.
REQ-014 SHALL drive oReady = !full[t] | iReady[t] (combinational; iValid does not gate oReady).
REQ-015 SHALL accept a word when iValid & oReady; on the next edge write iD into buffer t and set full[t] (latency 1 cycle to oValid[t]).
REQ-016 SHALL drain channel n when oValid[n] & iReady[n]; clear full[n] on the edge unless refilled the same cycle.
REQ-017 SHALL on simultaneous drain and accept into the same channel keep oValid[n]=1 and load the new word (no bubble).
REQ-018 SHALL keep oZn stable while oValid[n]=1 and iReady[n]=0 (no overwrite of a full, stalled channel).
REQ-019 SHALL retain last value on oZn after drain; channels other than t unaffected by an accept.
REQ-020 SHALL let each channel drain independently; all four may drain in one cycle.
REQ-021 SHALL ignore iD/iS1/iS0 when iValid=0; select changes while stalled only retarget oReady.

Reset
REQ-022 SHALL on iRst_n=0, asynchronously clear oValid to 4'b0000, oZ0..oZ3 to 0, counters (if built) to 0.
REQ-023 SHALL discard any buffered words on reset mid-operation; first accept after deassertion behaves as from empty.
REQ-024 SHALL drive oReady=1 during and after reset (all buffers empty).

Configuration
REQ-025 SHALL, with DMUX_COUNT_EN defined, add output oCnt0..oCnt3 (8 bits each), incrementing on each drain of channel n, wrapping 8'hFF -> 8'h00.
REQ-026 SHALL, without DMUX_COUNT_EN, omit oCnt ports and counter logic entirely; all other behaviour identical.

Structure
REQ-027 SHALL place WIDTH default, channel count (4), counter width (8) and channel index enum CH0..CH3 in shared package dmux_pkg.
REQ-028 SHALL implement the per-channel buffer as sub-module dmux_slot (load, drain, full, data, optional counter), instantiated four times.

Verification
REQ-029 SHALL cover: reset, then iD=4'b0011, {iS1,iS0}=2'b01, iValid=1 one cycle, iReady=4'b0000 -> next cycle oValid=4'b0010, oZ1=4'b0011, others 0.
REQ-030 SHALL cover: channel 2 full (4'b1100), iReady[2]=0, new word 4'b1111 to channel 2 -> oReady=0, oZ2 stays 4'b1100 until iReady[2]=1.
REQ-031 SHALL cover: channel 3 full, iReady[3]=1 and accept 4'b0101 to channel 3 same cycle -> oValid[3] stays 1, oZ3=4'b0101 next cycle.
REQ-032 SHALL cover: fill all four channels with 4'b0000,4'b0011,4'b1100,4'b1111, iReady=4'b1111 one cycle -> oValid=4'b0000, oZ values retained.
REQ-033 SHALL cover: iRst_n pulsed low mid-stream with oValid=4'b1010 -> oValid=0, oZ all 0 immediately, oReady=1.
REQ-034 SHALL cover (DMUX_COUNT_EN): 257 drains on channel 0 -> oCnt0=8'h01 after wrap.
